// File: rtl/dphy_deskew_pkg.sv
// Shared types and helpers for the D-PHY lane deskew block.
package dphy_deskew_pkg;

  typedef enum logic [1:0] {IDLE, SEEK, LOCKED} deskew_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } lane_byte_t;

  function automatic int skew_w(input int max_skew);
    return $clog2(max_skew + 1);
  endfunction

endpackage

// File: rtl/dphy_lane_delay.sv
// One lane of the deskewer: byte history, arrival run counter and the
// delay-select mux that picks the aligned byte out of the history.
module dphy_lane_delay
  import dphy_deskew_pkg::*;
#(
  parameter int MAX_SKEW = 3,
  parameter int SKEW_W   = skew_w(MAX_SKEW),
  parameter int RUN_W    = $clog2(MAX_SKEW + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              din_valid,
  input  logic [7:0]        din_data,
  input  logic [SKEW_W-1:0] sel,
  output logic [RUN_W-1:0]  run,
  output logic              dout_valid,
  output logic [7:0]        dout_data
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_SKEW + 1);

  lane_byte_t hist [MAX_SKEW+1];
  lane_byte_t picked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= MAX_SKEW; k++) begin
        hist[k] <= '0;
      end
    end else if (enable) begin
      hist[0] <= {din_valid, din_data};
      for (int k = 1; k <= MAX_SKEW; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  // clear wins over a frozen enable so a packet-done re-arm always lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= '0;
    end else if (clear) begin
      run <= '0;
    end else if (enable && din_valid && run != RUN_MAX) begin
      run <= run + 1'b1;
    end
  end

  always_comb begin
    picked = '0;
    for (int k = 0; k <= MAX_SKEW; k++) begin
      if (sel == SKEW_W'(k)) begin
        picked = hist[k];
      end
    end
  end

  assign dout_valid = picked.valid;
  assign dout_data  = picked.data;

endmodule

// File: rtl/dphy_lane_deskew.sv
// Aligns per-lane D-PHY byte streams into lane-parallel words, locking on
// the last-arriving lane and flagging false starts and lane dropouts.
module dphy_lane_deskew
  import dphy_deskew_pkg::*;
#(
  parameter int DATA_LANES = 4,
  parameter int MAX_SKEW   = 3,
  parameter int ERR_CNT_W  = 16,
  localparam int SKEW_W    = skew_w(MAX_SKEW)
) (
  input  logic                         byte_clk_i,
  input  logic                         rst_n_i,
  input  logic                         enable_i,
  input  logic [DATA_LANES-1:0]        lane_mask_i,
  input  logic                         pkt_done_i,
  input  logic [DATA_LANES*8-1:0]      byte_data_i,
  input  logic [DATA_LANES-1:0]        valid_i,
  output logic                         sync_reset_o,
  output logic [DATA_LANES*8-1:0]      word_o,
  output logic                         valid_o,
  output logic [DATA_LANES*SKEW_W-1:0] skew_o,
  output logic                         align_err_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o
);

  localparam int RUN_W = $clog2(MAX_SKEW + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_SKEW + 1);

  deskew_state_t state, state_next;

  logic [DATA_LANES-1:0]        mask;
  logic [DATA_LANES-1:0]        active;
  logic [DATA_LANES-1:0]        has_run;
  logic [DATA_LANES-1:0]        run_full;
  logic [DATA_LANES-1:0]        aligned_valid;
  logic [DATA_LANES*8-1:0]      aligned_data;
  logic [DATA_LANES*8-1:0]      lane_word;
  logic [DATA_LANES*SKEW_W-1:0] sel;
  logic [RUN_W-1:0]             run [DATA_LANES];
  logic                         run_clear;
  logic                         err_event;
  logic                         start;
  logic                         lock;

  // The live mask only matters for the IDLE exit decision; afterwards the latched copy rules.
  assign active = (state == IDLE) ? lane_mask_i : mask;

  for (genvar gi = 0; gi < DATA_LANES; gi++) begin : g_lane
    dphy_lane_delay #(
      .MAX_SKEW (MAX_SKEW),
      .SKEW_W   (SKEW_W),
      .RUN_W    (RUN_W)
    ) u_delay (
      .clk        (byte_clk_i),
      .rst_n      (rst_n_i),
      .enable     (enable_i),
      .clear      (run_clear),
      .din_valid  (valid_i[gi]),
      .din_data   (byte_data_i[gi*8 +: 8]),
      .sel        (sel[gi*SKEW_W +: SKEW_W]),
      .run        (run[gi]),
      .dout_valid (aligned_valid[gi]),
      .dout_data  (aligned_data[gi*8 +: 8])
    );

    assign has_run[gi]  = (run[gi] != '0);
    assign run_full[gi] = (run[gi] == RUN_MAX);

    // While seeking, an early lane's delay is how many bytes it has banked.
    assign sel[gi*SKEW_W +: SKEW_W] = !active[gi]       ? '0 :
                                      (state == LOCKED) ? skew_o[gi*SKEW_W +: SKEW_W] :
                                                          SKEW_W'(run[gi] - 1'b1);

    assign lane_word[gi*8 +: 8] = active[gi] ? aligned_data[gi*8 +: 8] : 8'h00;
  end

  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    err_event  = 1'b0;
    start      = 1'b0;
    lock       = 1'b0;
    if (enable_i) begin
      case (state)
        IDLE: begin
          if (|(valid_i & lane_mask_i)) begin
            state_next = SEEK;
            start      = 1'b1;
          end
        end
        SEEK: begin
          // Lock has priority so a skew of exactly MAX_SKEW still locks.
          if (&(~active | has_run)) begin
            state_next = LOCKED;
            lock       = 1'b1;
          end else if (|(active & run_full)) begin
            state_next = IDLE;
            err_event  = 1'b1;
          end
        end
        LOCKED: begin
          if (!(&(~active | aligned_valid))) begin
            state_next = IDLE;
            err_event  = |(active & aligned_valid);
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (pkt_done_i) begin
      state_next = IDLE;
      err_event  = 1'b0;
      start      = 1'b0;
      lock       = 1'b0;
    end
  end

  assign run_clear    = pkt_done_i | (state_next == IDLE);
  assign align_err_o  = err_event;
  assign sync_reset_o = pkt_done_i | err_event;

  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask      <= '0;
      word_o    <= '0;
      valid_o   <= 1'b0;
      skew_o    <= '0;
      err_cnt_o <= '0;
    end else begin
      if (start) begin
        mask <= lane_mask_i;
      end
      if (lock) begin
        skew_o <= sel;
      end
      if (pkt_done_i) begin
        valid_o <= 1'b0;
      end else if (enable_i) begin
        valid_o <= (state_next == LOCKED);
        if (state_next == LOCKED) begin
          word_o <= lane_word;
        end
      end
      if (err_event && err_cnt_o != '1) begin
        err_cnt_o <= err_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dphy_lane_deskew.sv
// Randomized and directed bench for dphy_lane_deskew against a sample-log
// reference model of the deskew rules.
module tb_dphy_lane_deskew;

  localparam int L    = 4;
  localparam int MS   = 3;
  localparam int LOGN = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        pkt_done;
  logic [3:0]  lane_mask;
  logic [3:0]  valid;
  logic [31:0] byte_data;
  logic        sync_reset;
  logic        valid_out;
  logic        align_err;
  logic [31:0] word;
  logic [7:0]  skew;
  logic [15:0] err_cnt;

  dphy_lane_deskew #(
    .DATA_LANES (L),
    .MAX_SKEW   (MS),
    .ERR_CNT_W  (16)
  ) dut (
    .byte_clk_i   (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .lane_mask_i  (lane_mask),
    .pkt_done_i   (pkt_done),
    .byte_data_i  (byte_data),
    .valid_i      (valid),
    .sync_reset_o (sync_reset),
    .word_o       (word),
    .valid_o      (valid_out),
    .skew_o       (skew),
    .align_err_o  (align_err),
    .err_cnt_o    (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: every enabled sample is logged; alignment is read back by index.
  logic [7:0]  log_d [L][LOGN];
  logic        log_v [L][LOGN];
  int          ecount;
  int          m_state;   // 0 idle, 1 seeking, 2 locked
  logic [3:0]  m_mask;
  int          ts;
  int          m_skew [L];
  logic [31:0] m_word;
  logic        m_valid;
  int          m_cnt;
  logic        last_align;
  logic        last_sync;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hv(input int lane, input int idx);
    return (idx < 0) ? 1'b0 : log_v[lane][idx];
  endfunction

  function automatic logic [7:0] hd(input int lane, input int idx);
    return (idx < 0) ? 8'h00 : log_d[lane][idx];
  endfunction

  function automatic logic [31:0] model_word();
    logic [31:0] w = '0;
    for (int i = 0; i < L; i++) begin
      if (m_mask[i]) w[i*8 +: 8] = hd(i, ecount - 1 - m_skew[i]);
    end
    return w;
  endfunction

  function automatic logic [7:0] model_skew();
    logic [7:0] s = '0;
    for (int i = 0; i < L; i++) s[i*2 +: 2] = 2'(m_skew[i]);
    return s;
  endfunction

  task automatic model_reset();
    ecount  = 0;
    m_state = 0;
    m_mask  = '0;
    ts      = 0;
    m_word  = '0;
    m_valid = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < L; i++) m_skew[i] = 0;
  endtask

  // One byte-clock cycle: check registered outputs, drive inputs, check
  // combinational outputs, advance the model, then let the edge happen.
  task automatic step(input logic en, input logic [3:0] mask, input logic pd,
                      input logic [31:0] data, input logic [3:0] vld);
    logic err;
    logic lock;
    logic fs;
    int   c;
    int   nh;
    int   nl;
    int   cnt [L];
    @(negedge clk);
    chk("valid_o", valid_out, m_valid);
    if (m_valid) chk("word_o", word, m_word);
    chk("skew_o", skew, model_skew());
    chk("err_cnt_o", err_cnt, m_cnt);
    enable    = en;
    lane_mask = mask;
    pkt_done  = pd;
    byte_data = data;
    valid     = vld;
    #1;
    err = 1'b0;
    if (pd) begin
      m_state = 0;
      m_valid = 1'b0;
    end else if (en) begin
      case (m_state)
        0: begin
          if ((vld & mask) != 4'h0) begin
            m_state = 1;
            m_mask  = mask;
            ts      = ecount;
          end
        end
        1: begin
          lock = 1'b1;
          fs   = 1'b0;
          for (int i = 0; i < L; i++) begin
            c = 0;
            for (int k = ts; k < ecount; k++) if (log_v[i][k]) c++;
            cnt[i] = c;
            if (m_mask[i] && c == 0) lock = 1'b0;
            if (m_mask[i] && c >= MS + 1) fs = 1'b1;
          end
          if (lock) begin
            for (int i = 0; i < L; i++) m_skew[i] = m_mask[i] ? cnt[i] - 1 : 0;
            m_word  = model_word();
            m_valid = 1'b1;
            m_state = 2;
          end else if (fs) begin
            err     = 1'b1;
            m_state = 0;
          end
        end
        default: begin
          nh = 0;
          nl = 0;
          for (int i = 0; i < L; i++) begin
            if (m_mask[i]) begin
              if (hv(i, ecount - 1 - m_skew[i])) nh++;
              else nl++;
            end
          end
          if (nl == 0) begin
            m_word  = model_word();
            m_valid = 1'b1;
          end else begin
            m_valid = 1'b0;
            m_state = 0;
            err     = (nh != 0);
          end
        end
      endcase
    end
    chk("align_err_o", align_err, err);
    chk("sync_reset_o", sync_reset, pd | err);
    last_align = align_err;
    last_sync  = sync_reset;
    if (err && m_cnt != 65535) m_cnt++;
    if (en) begin
      for (int i = 0; i < L; i++) begin
        log_v[i][ecount] = vld[i];
        log_d[i][ecount] = data[i*8 +: 8];
      end
      ecount++;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    enable    = 1'b0;
    pkt_done  = 1'b0;
    valid     = '0;
    byte_data = '0;
    lane_mask = '0;
    #1;
    chk("rst_valid_o", valid_out, 1'b0);
    chk("rst_word_o", word, 32'h0);
    chk("rst_skew_o", skew, 8'h0);
    chk("rst_err_cnt_o", err_cnt, 16'h0);
    chk("rst_align_err_o", align_err, 1'b0);
    chk("rst_sync_reset_o", sync_reset, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bytes 4j+lane; even lanes one byte clock ahead of odd lanes.
  task automatic skewed_packet();
    logic [31:0] d;
    logic [3:0]  v;
    for (int j = 0; j < 8; j++) begin
      d = '0;
      v = '0;
      for (int i = 0; i < L; i++) begin
        if (i % 2 == 0) begin
          if (j < 5) begin
            v[i] = 1'b1;
            d[i*8 +: 8] = 8'(4 * j + i);
          end
        end else if (j >= 1 && j <= 5) begin
          v[i] = 1'b1;
          d[i*8 +: 8] = 8'(4 * (j - 1) + i);
        end
      end
      step(1'b1, 4'hF, 1'b0, d, v);
      #2;
      if (j == 1) chk("skewed_valid_early", valid_out, 1'b0);
      if (j == 2) begin
        chk("skewed_valid_first", valid_out, 1'b1);
        chk("skewed_word_first", word, 32'h03020100);
        chk("skewed_skew", skew, 8'h11);
      end
    end
    chk("skewed_no_err", err_cnt, 16'h0);
    $display("txn skewed_packet done at %0t", $time);
  endtask

  task automatic rand_packet(input int p);
    logic [3:0]  mask;
    logic [31:0] d;
    logic [3:0]  v;
    logic        en;
    logic        pd;
    int          off [L];
    int          len;
    int          drop_lane;
    int          drop_j;
    mask      = ($urandom_range(7, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
    len       = $urandom_range(6, 1);
    drop_lane = ($urandom_range(5, 0) == 0) ? $urandom_range(L - 1, 0) : -1;
    drop_j    = $urandom_range(len - 1, 0);
    for (int i = 0; i < L; i++) begin
      off[i] = ($urandom_range(5, 0) == 0) ? MS + 1 : $urandom_range(MS, 0);
    end
    for (int j = 0; j < MS + len + 4; j++) begin
      d = $urandom();
      v = '0;
      for (int i = 0; i < L; i++) begin
        v[i] = (j >= off[i]) && (j < off[i] + len) && !(i == drop_lane && j == off[i] + drop_j);
      end
      en = ($urandom_range(9, 0) != 0);
      pd = ($urandom_range(39, 0) == 0);
      step(en, mask, pd, d, v);
    end
    $display("txn random_packet %0d mask %h len %0d err_cnt %0d", p, mask, len, err_cnt);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  v;
    rst_n     = 1'b0;
    enable    = 1'b0;
    pkt_done  = 1'b0;
    lane_mask = '0;
    valid     = '0;
    byte_data = '0;
    model_reset();
    #1;
    chk("init_valid_o", valid_out, 1'b0);
    chk("init_word_o", word, 32'h0);
    chk("init_skew_o", skew, 8'h0);
    chk("init_err_cnt_o", err_cnt, 16'h0);
    chk("init_align_err_o", align_err, 1'b0);
    chk("init_sync_reset_o", sync_reset, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    skewed_packet();

    // Lane 0 alone for MAX_SKEW+1 bytes: false start.
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 4'hF, 1'b0, $urandom(), (j < 4) ? 4'b0001 : 4'b0000);
      #2;
      if (j == 3) chk("fs_no_early_err", last_align, 1'b0);
      if (j == 4) begin
        chk("fs_align_err", last_align, 1'b1);
        chk("fs_sync_reset", last_sync, 1'b1);
        chk("fs_err_cnt", err_cnt, 16'd1);
        chk("fs_valid_low", valid_out, 1'b0);
      end
    end
    $display("txn false_start done at %0t", $time);

    // Skew of exactly MAX_SKEW still locks.
    for (int j = 0; j < 10; j++) begin
      v = '0;
      v[0] = (j < 4);
      for (int i = 1; i < L; i++) v[i] = (j >= 3 && j < 7);
      step(1'b1, 4'hF, 1'b0, $urandom(), v);
      #2;
      if (j == 4) begin
        chk("maxskew_no_err", last_align, 1'b0);
        chk("maxskew_valid", valid_out, 1'b1);
        chk("maxskew_skew", skew, 8'h03);
      end
    end
    chk("maxskew_err_cnt", err_cnt, 16'd1);
    $display("txn max_skew_lock done at %0t", $time);

    // Two-lane mask with garbage on the idle lanes.
    for (int j = 0; j < 9; j++) begin
      d = $urandom();
      v = '0;
      v[0] = (j < 4);
      v[1] = (j >= 2 && j < 6);
      step(1'b1, 4'h3, 1'b0, d, v);
      #2;
      if (j == 3) begin
        chk("mask3_valid", valid_out, 1'b1);
        chk("mask3_word_hi", word[31:16], 16'h0);
        chk("mask3_skew", skew, 8'h02);
      end
    end
    $display("txn two_lane_mask done at %0t", $time);

    // Lane 2 drops out while locked.
    for (int j = 0; j < 7; j++) begin
      v = (j < 3) ? 4'hF : (j == 3) ? 4'b1011 : 4'h0;
      step(1'b1, 4'hF, 1'b0, $urandom(), v);
      #2;
      if (j == 3) chk("drop_no_early_err", last_align, 1'b0);
      if (j == 4) begin
        chk("drop_align_err", last_align, 1'b1);
        chk("drop_valid_low", valid_out, 1'b0);
        chk("drop_err_cnt", err_cnt, 16'd2);
      end
    end
    $display("txn dropout done at %0t", $time);

    // Packet done coincides with a false start: error suppressed.
    for (int j = 0; j < 7; j++) begin
      step(1'b1, 4'hF, (j == 4), $urandom(), (j < 4) ? 4'b0001 : 4'b0000);
      #2;
      if (j == 4) begin
        chk("pd_sync_reset", last_sync, 1'b1);
        chk("pd_align_err", last_align, 1'b0);
        chk("pd_err_cnt", err_cnt, 16'd2);
      end
    end
    $display("txn pkt_done_vs_false_start done at %0t", $time);

    // Lock, freeze with enable low, then reset mid-packet.
    for (int j = 0; j < 4; j++) begin
      d = '0;
      for (int i = 0; i < L; i++) d[i*8 +: 8] = 8'(4 * j + i);
      step(1'b1, 4'hF, 1'b0, d, 4'hF);
    end
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 4'($urandom_range(15, 0)), 1'b0, $urandom(), 4'($urandom_range(15, 0)));
      #2;
      chk("freeze_word", word, 32'h0b0a0908);
      chk("freeze_valid", valid_out, 1'b1);
    end
    do_reset();
    $display("txn freeze_and_reset done at %0t", $time);
    skewed_packet();

    for (int p = 0; p < 80; p++) rand_packet(p);
    step(1'b1, 4'hF, 1'b1, 32'h0, 4'h0);
    step(1'b1, 4'hF, 1'b0, 32'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
